// File: rtl/sprite_motion_ctrl.sv
// Joystick-driven two-axis sprite position controller with clamped bounds.
// Optional speed ramp FSM enabled by defining SPRITE_MOTION_ACCEL_EN.
module sprite_motion_ctrl #(
  parameter int ROW_W       = 9,
  parameter int COL_W       = 10,
  parameter int ROW_MIN     = 0,
  parameter int ROW_MAX     = 463,
  parameter int COL_MIN     = 0,
  parameter int COL_MAX     = 623,
  parameter int START_ROW   = 350,
  parameter int START_COL   = 310,
  parameter int TICK_DIV    = 416667,
  parameter int DEAD_LO     = 4,
  parameter int DEAD_HI     = 6,
  parameter int STEP_SLOW   = 2,
  parameter int STEP_FAST   = 6,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       Joy_X,
  input  logic [3:0]       Joy_Y,
  input  logic             Freeze,
  input  logic             Spawn,
  output logic [ROW_W-1:0] Row,
  output logic [COL_W-1:0] Col,
  output logic             Move_Tick,
  output logic             Moving,
  output logic [3:0]       At_Edge
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic signed [ROW_W:0] RMIN =
    (ROW_W+1)'(ROW_MIN);
  localparam logic signed [ROW_W:0] RMAX =
    (ROW_W+1)'(ROW_MAX);
  localparam logic signed [COL_W:0] CMIN =
    (COL_W+1)'(COL_MIN);
  localparam logic signed [COL_W:0] CMAX =
    (COL_W+1)'(COL_MAX);

  logic [CNT_W-1:0] cnt;
  logic             tick_due;

  logic x_pos, x_neg, y_pos, y_neg;
  logic any_dir;
  logic [7:0] step;

  logic signed [ROW_W:0] row_ext, row_stp, row_sum;
  logic signed [COL_W:0] col_ext, col_stp, col_sum;
  logic [ROW_W-1:0] row_new;
  logic [COL_W-1:0] col_new;

  assign tick_due  = (cnt == CNT_W'(TICK_DIV-1));
  assign Move_Tick = tick_due & ~Spawn;

  assign x_neg = (Joy_X < 4'(DEAD_LO));
  assign x_pos = (Joy_X > 4'(DEAD_HI));
  assign y_neg = (Joy_Y < 4'(DEAD_LO));
  assign y_pos = (Joy_Y > 4'(DEAD_HI));
  assign any_dir = x_neg | x_pos | y_neg | y_pos;

  // Sums are one bit wider and signed so over/underflow clamps, never wraps
  always_comb begin
    row_ext = $signed({1'b0, Row});
    col_ext = $signed({1'b0, Col});
    row_stp = (ROW_W+1)'(step);
    col_stp = (COL_W+1)'(step);
    row_sum = row_ext;
    col_sum = col_ext;
    if (y_pos) row_sum = row_ext + row_stp;
    if (y_neg) row_sum = row_ext - row_stp;
    if (x_pos) col_sum = col_ext + col_stp;
    if (x_neg) col_sum = col_ext - col_stp;
    row_new = row_sum[ROW_W-1:0];
    col_new = col_sum[COL_W-1:0];
    if (row_sum > RMAX) row_new = ROW_W'(ROW_MAX);
    if (row_sum < RMIN) row_new = ROW_W'(ROW_MIN);
    if (col_sum > CMAX) col_new = COL_W'(COL_MAX);
    if (col_sum < CMIN) col_new = COL_W'(COL_MIN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      Row <= ROW_W'(START_ROW);
      Col <= COL_W'(START_COL);
    end else if (Spawn) begin
      cnt <= '0;
      Row <= ROW_W'(START_ROW);
      Col <= COL_W'(START_COL);
    end else begin
      cnt <= tick_due ? '0 : cnt + 1'b1;
      if (Move_Tick && !Freeze) begin
        Row <= row_new;
        Col <= col_new;
      end
    end
  end

  assign At_Edge = {
    Col == COL_W'(COL_MAX),
    Col == COL_W'(COL_MIN),
    Row == ROW_W'(ROW_MAX),
    Row == ROW_W'(ROW_MIN)
  };

`ifdef SPRITE_MOTION_ACCEL_EN

  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SLOW,
    FAST
  } state_t;

  state_t state, state_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [1:0] prev_x, prev_y, prev_x_nx, prev_y_nx;
  logic reversal;

  // Direction pairs are {neg,pos}; a reversal is a direct neg<->pos swap
  assign reversal =
    (prev_x[1] & x_pos) | (prev_x[0] & x_neg) |
    (prev_y[1] & y_pos) | (prev_y[0] & y_neg);

  assign step = (state == FAST && !reversal) ?
    8'(STEP_FAST) : 8'(STEP_SLOW);

  always_comb begin
    state_nx  = state;
    hold_nx   = hold;
    prev_x_nx = prev_x;
    prev_y_nx = prev_y;
    if (Spawn || Freeze) begin
      state_nx  = IDLE;
      hold_nx   = '0;
      prev_x_nx = 2'b00;
      prev_y_nx = 2'b00;
    end else if (Move_Tick) begin
      prev_x_nx = {x_neg, x_pos};
      prev_y_nx = {y_neg, y_pos};
      if (!any_dir) begin
        state_nx = IDLE;
        hold_nx  = '0;
      end else if (reversal) begin
        state_nx = SLOW;
        hold_nx  = '0;
      end else begin
        unique case (state)
          IDLE: begin
            state_nx = SLOW;
            hold_nx  = HOLD_W'(1);
          end
          SLOW: begin
            if (hold >= HOLD_W'(ACCEL_TICKS-1)) begin
              state_nx = FAST;
              hold_nx  = '0;
            end else begin
              hold_nx = hold + 1'b1;
            end
          end
          FAST: state_nx = FAST;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      hold   <= '0;
      prev_x <= 2'b00;
      prev_y <= 2'b00;
    end else begin
      state  <= state_nx;
      hold   <= hold_nx;
      prev_x <= prev_x_nx;
      prev_y <= prev_y_nx;
    end
  end

  assign Moving = (state != IDLE);

`else

  logic moving_q;

  assign step = 8'(STEP_SLOW);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      moving_q <= 1'b0;
    end else if (Spawn || Freeze) begin
      moving_q <= 1'b0;
    end else if (Move_Tick) begin
      moving_q <= any_dir;
    end
  end

  assign Moving = moving_q;

`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with TICK_DIV=4.
// Edge instances start next to the bounds to exercise clamping.
module tb_sprite_motion_ctrl;

  logic       Clk;
  logic       Reset;
  logic [3:0] Joy_X;
  logic [3:0] Joy_Y;
  logic       Freeze;
  logic       Spawn;

  logic [8:0] row, row_hi, row_lo;
  logic [9:0] col, col_hi, col_lo;
  logic       move_tick, tick_hi, tick_lo;
  logic       moving, moving_hi, moving_lo;
  logic [3:0] at_edge, edge_hi, edge_lo;

  int total = 0;
  int bad   = 0;

  sprite_motion_ctrl #(.TICK_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Joy_X(Joy_X), .Joy_Y(Joy_Y),
    .Freeze(Freeze), .Spawn(Spawn), .Row(row), .Col(col),
    .Move_Tick(move_tick), .Moving(moving), .At_Edge(at_edge)
  );

  sprite_motion_ctrl #(
    .TICK_DIV(4), .START_ROW(462), .START_COL(622)
  ) dut_hi (
    .Clk(Clk), .Reset(Reset), .Joy_X(Joy_X), .Joy_Y(Joy_Y),
    .Freeze(Freeze), .Spawn(Spawn), .Row(row_hi), .Col(col_hi),
    .Move_Tick(tick_hi), .Moving(moving_hi), .At_Edge(edge_hi)
  );

  sprite_motion_ctrl #(
    .TICK_DIV(4), .START_ROW(1), .START_COL(1)
  ) dut_lo (
    .Clk(Clk), .Reset(Reset), .Joy_X(Joy_X), .Joy_Y(Joy_Y),
    .Freeze(Freeze), .Spawn(Spawn), .Row(row_lo), .Col(col_lo),
    .Move_Tick(tick_lo), .Moving(moving_lo), .At_Edge(edge_lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Returns at the negedge after the next tick, with its update visible
  task automatic next_tick();
    int n = 0;
    while (move_tick !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (move_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got=%b want=1", move_tick);
    end
    @(negedge Clk);
  endtask

  task automatic do_spawn();
    Spawn = 1'b1;
    @(negedge Clk);
    Spawn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Joy_X = 4'd5;
    Joy_Y = 4'd5;
    Freeze = 1'b0;
    Spawn = 1'b0;
    repeat (2) @(negedge Clk);
    total++;
    if (row !== 9'd350 || col !== 10'd310) begin
      bad++;
      $display("FAIL reset_pos got=%0d/%0d want=350/310", row, col);
    end
    total++;
    if (moving !== 1'b0 || move_tick !== 1'b0 || at_edge !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b%b%b want=000000",
               moving, move_tick, at_edge);
    end
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (move_tick !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL tick_period cyc=%0d got=%b want=%b",
                 i, move_tick, (i % 4) == 3);
      end
      @(negedge Clk);
    end
    total++;
    if (row !== 9'd350 || col !== 10'd310 || moving !== 1'b0) begin
      bad++;
      $display("FAIL neutral_hold got=%0d/%0d/%b want=350/310/0",
               row, col, moving);
    end
  endtask

  task automatic test_hold_right();
    int exp_col;
    do_spawn();
    Joy_X = 4'd15;
    Joy_Y = 4'd5;
    for (int k = 1; k <= 10; k++) begin
      next_tick();
`ifdef SPRITE_MOTION_ACCEL_EN
      exp_col = (k <= 8) ? 310 + 2*k : 326 + 6*(k-8);
`else
      exp_col = 310 + 2*k;
`endif
      total++;
      if (col !== 10'(exp_col) || row !== 9'd350 || moving !== 1'b1) begin
        bad++;
        $display("FAIL hold_right tick=%0d got=%0d/%0d/%b want=%0d/350/1",
                 k, col, row, moving, exp_col);
      end
    end
  endtask

  task automatic test_reversal();
    int c0;
`ifdef SPRITE_MOTION_ACCEL_EN
    c0 = 338;
`else
    c0 = 330;
`endif
    Joy_X = 4'd0;
    next_tick();
    total++;
    if (col !== 10'(c0 - 2) || moving !== 1'b1) begin
      bad++;
      $display("FAIL reversal got=%0d/%b want=%0d/1", col, moving, c0 - 2);
    end
    next_tick();
    total++;
    if (col !== 10'(c0 - 4)) begin
      bad++;
      $display("FAIL after_rev_slow got=%0d want=%0d", col, c0 - 4);
    end
    Joy_X = 4'd5;
    next_tick();
    total++;
    if (col !== 10'(c0 - 4) || moving !== 1'b0) begin
      bad++;
      $display("FAIL neutral_idle got=%0d/%b want=%0d/0",
               col, moving, c0 - 4);
    end
  endtask

  task automatic test_edges();
    do_spawn();
    Joy_X = 4'd15;
    Joy_Y = 4'd15;
    for (int k = 0; k < 2; k++) begin
      next_tick();
      total++;
      if (col_hi !== 10'd623 || row_hi !== 9'd463 || edge_hi !== 4'b1010) begin
        bad++;
        $display("FAIL clamp_high tick=%0d got=%0d/%0d/%b want=623/463/1010",
                 k, col_hi, row_hi, edge_hi);
      end
    end
    total++;
    if (col !== 10'd314 || row !== 9'd354) begin
      bad++;
      $display("FAIL diag_down_right got=%0d/%0d want=314/354", col, row);
    end
    do_spawn();
    Joy_X = 4'd0;
    Joy_Y = 4'd0;
    for (int k = 0; k < 2; k++) begin
      next_tick();
      total++;
      if (col_lo !== 10'd0 || row_lo !== 9'd0 || edge_lo !== 4'b0101) begin
        bad++;
        $display("FAIL clamp_low tick=%0d got=%0d/%0d/%b want=0/0/0101",
                 k, col_lo, row_lo, edge_lo);
      end
    end
    total++;
    if (col !== 10'd306 || row !== 9'd346) begin
      bad++;
      $display("FAIL diag_up_left got=%0d/%0d want=306/346", col, row);
    end
    Joy_X = 4'd5;
    Joy_Y = 4'd5;
  endtask

  task automatic test_freeze();
    int n;
    do_spawn();
    Joy_X = 4'd15;
    next_tick();
    total++;
    if (col !== 10'd312 || moving !== 1'b1) begin
      bad++;
      $display("FAIL pre_freeze got=%0d/%b want=312/1", col, moving);
    end
    Freeze = 1'b1;
    @(negedge Clk);
    total++;
    if (moving !== 1'b0) begin
      bad++;
      $display("FAIL freeze_moving got=%b want=0", moving);
    end
    next_tick();
    total++;
    if (col !== 10'd312 || moving !== 1'b0) begin
      bad++;
      $display("FAIL freeze_hold got=%0d/%b want=312/0", col, moving);
    end
    Freeze = 1'b0;
    n = 0;
    while (move_tick !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    Spawn = 1'b1;
    Freeze = 1'b1;
    #1;
    total++;
    if (move_tick !== 1'b0 || n >= 20) begin
      bad++;
      $display("FAIL spawn_suppress got=%b want=0 wait=%0d", move_tick, n);
    end
    @(negedge Clk);
    Spawn = 1'b0;
    Freeze = 1'b0;
    total++;
    if (col !== 10'd310 || row !== 9'd350 || moving !== 1'b0) begin
      bad++;
      $display("FAIL spawn_freeze got=%0d/%0d/%b want=310/350/0",
               col, row, moving);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (move_tick !== (i == 3)) begin
        bad++;
        $display("FAIL spawn_prescale cyc=%0d got=%b want=%b",
                 i, move_tick, i == 3);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid();
    do_spawn();
    Joy_X = 4'd15;
    next_tick();
    next_tick();
    Reset = 1'b1;
    #1;
    total++;
    if (col !== 10'd310 || row !== 9'd350 || moving !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got=%0d/%0d/%b want=310/350/0",
               col, row, moving);
    end
    @(negedge Clk);
    Reset = 1'b0;
    Joy_X = 4'd5;
  endtask

  initial begin
    test_reset();
    test_hold_right();
    test_reversal();
    test_edges();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
